// File: rtl/spi_xfer_sequencer.sv
// SPI transaction sequencer for the I2C-to-SPI bridge.
// Takes a header byte plus optional payload from the I2C side, drives chip
// select, hands one byte at a time to the SPI byte engine and queues the
// captured MISO bytes in a small first-word-fall-through response FIFO.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a header byte, cs_n high
// S_SETUP | cs_n low, counting setup cycles before the first byte
// S_LOAD  | fetching the next tx byte (payload or 8'hFF filler)
// S_XFER  | engine busy with one byte, timeout running
// S_STORE | pushing the captured rx byte, stalls while the FIFO is full
// S_NEXT  | one byte finished, decide on another byte or hold
// S_HOLD  | counting hold cycles before cs_n is released
// S_DRAIN | timeout abort: cs_n high, discarding unsent payload bytes
//
// CS_SETUP and CS_HOLD are expected to be at least 1.
module spi_xfer_sequencer #(
  parameter int RSP_DEPTH = 4,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic       i2c_wb_clk_i,
  input  logic       i2c_wb_rst_i,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       spi_start,
  output logic [7:0] spi_tx,
  input  logic       spi_done,
  input  logic [7:0] spi_rx,
  output logic       cs_n,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       rsp_ready,
  output logic       busy,
  output logic       err
);

  localparam int AW = $clog2(RSP_DEPTH);
  localparam int TW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOAD, S_XFER, S_STORE, S_NEXT, S_HOLD, S_DRAIN
  } state_t;

  state_t        state_q;
  logic          cs_n_q, start_q, rdy_q, err_q, w_q, r_q;
  logic [7:0]    tx_q, rx_q;
  logic [4:0]    rem_q;
  logic [TW-1:0] tmr_q;

  logic [7:0]    mem_q [RSP_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          fifo_full, fifo_empty, push, pop;

  // Header bits 5:4 carry no meaning for this block.
  logic hdr_unused;
  assign hdr_unused = ^cmd_data[5:4];

  assign fifo_full  = (cnt_q == (AW+1)'(RSP_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign push       = (state_q == S_STORE) && !fifo_full;
  assign pop        = rsp_ready && !fifo_empty;

  // Transaction FSM; every output it drives is registered.
  always_ff @(posedge i2c_wb_clk_i or posedge i2c_wb_rst_i) begin
    if (i2c_wb_rst_i) begin
      state_q <= S_IDLE;
      cs_n_q  <= 1'b1;
      start_q <= 1'b0;
      tx_q    <= 8'hFF;
      rx_q    <= 8'h00;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      w_q     <= 1'b0;
      r_q     <= 1'b0;
      rem_q   <= '0;
      tmr_q   <= '0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          rdy_q <= 1'b1;
          if (rdy_q && cmd_valid) begin
            w_q     <= cmd_data[7];
            r_q     <= cmd_data[6];
            rem_q   <= {1'b0, cmd_data[3:0]} + 5'd1;
            tmr_q   <= TW'(CS_SETUP - 1);
            cs_n_q  <= 1'b0;
            rdy_q   <= 1'b0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tmr_q == '0) begin
            rdy_q   <= w_q;
            state_q <= S_LOAD;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        S_LOAD: begin
          if (!w_q) begin
            tx_q    <= 8'hFF;
            start_q <= 1'b1;
            tmr_q   <= TW'(TIMEOUT - 1);
            state_q <= S_XFER;
          end else if (rdy_q && cmd_valid) begin
            tx_q    <= cmd_data;
            rdy_q   <= 1'b0;
            start_q <= 1'b1;
            tmr_q   <= TW'(TIMEOUT - 1);
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          if (spi_done) begin
            rx_q    <= spi_rx;
            state_q <= r_q ? S_STORE : S_NEXT;
          end else if (tmr_q == '0) begin
            // The byte in flight is lost; what is left to discard excludes it.
            err_q   <= 1'b1;
            cs_n_q  <= 1'b1;
            rem_q   <= rem_q - 5'd1;
            rdy_q   <= w_q && (rem_q > 5'd1);
            state_q <= S_DRAIN;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        S_STORE: begin
          if (!fifo_full) state_q <= S_NEXT;
        end
        S_NEXT: begin
          rem_q <= rem_q - 5'd1;
          if (rem_q == 5'd1) begin
            tmr_q   <= TW'(CS_HOLD - 1);
            state_q <= S_HOLD;
          end else begin
            rdy_q   <= w_q;
            state_q <= S_LOAD;
          end
        end
        S_HOLD: begin
          if (tmr_q == '0) begin
            cs_n_q  <= 1'b1;
            rdy_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        S_DRAIN: begin
          if (!w_q || rem_q == '0) begin
            rdy_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (rdy_q && cmd_valid) begin
            rem_q <= rem_q - 5'd1;
            if (rem_q == 5'd1) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Occupancy change from this cycle's push/pop.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Response FIFO pointers and occupancy; pointers wrap at RSP_DEPTH.
  always_ff @(posedge i2c_wb_clk_i or posedge i2c_wb_rst_i) begin
    if (i2c_wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Response storage needs no reset; the head is masked while empty.
  always_ff @(posedge i2c_wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= rx_q;
  end

  assign cmd_ready = rdy_q;
  assign spi_start = start_q;
  assign spi_tx    = tx_q;
  assign cs_n      = cs_n_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = !fifo_empty;
  assign rsp_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a behavioural SPI byte engine.
module tb_spi_xfer_sequencer;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid, cmd_ready, spi_start, spi_done, cs_n;
  logic       rsp_valid, rsp_ready, busy, err;
  logic [7:0] cmd_data, spi_tx, spi_rx, rsp_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, n_start = 0, n_accept = 0, cs_low = 0;
  int err_cnt = 0, err_cyc = 0, last_start_cyc = 0;
  int eng_n = 0, hang_at = 0;
  int base, viol;
  logic       cs_at_err = 1'b0;
  logic [7:0] eng_tx;
  logic [7:0] tx_log[$];
  logic [7:0] rsp_log[$];
  logic [7:0] rx_q[$];

  spi_xfer_sequencer #(
    .RSP_DEPTH(4), .CS_SETUP(2), .CS_HOLD(2), .TIMEOUT(TMO)
  ) dut (
    .i2c_wb_clk_i(clk),
    .i2c_wb_rst_i(rst),
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
    .cmd_ready(cmd_ready),
    .spi_start(spi_start),
    .spi_tx(spi_tx),
    .spi_done(spi_done),
    .spi_rx(spi_rx),
    .cs_n(cs_n),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_ready(rsp_ready),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Mid-cycle observer of handshakes, chip select and error pulses.
  always @(negedge clk) begin
    cyc++;
    if (spi_start) begin
      n_start++;
      last_start_cyc = cyc;
      tx_log.push_back(spi_tx);
    end
    if (cmd_valid && cmd_ready) n_accept++;
    if (!cs_n) cs_low++;
    if (err) begin
      err_cnt++;
      err_cyc   = cyc;
      cs_at_err = cs_n;
    end
    if (rsp_valid && rsp_ready) rsp_log.push_back(rsp_data);
  end

  // Byte engine: done 8 cycles after start; rx from rx_q, else ~tx.
  initial begin
    spi_done = 1'b0;
    spi_rx   = 8'h00;
    forever begin
      @(negedge clk);
      if (spi_start && !rst) begin
        eng_n++;
        eng_tx = spi_tx;
        if (eng_n != hang_at) begin
          repeat (7) @(posedge clk);
          #1;
          if (busy) check_eq("tx_stable", int'(spi_tx), int'(eng_tx));
          if (rx_q.size() > 0) spi_rx = rx_q.pop_front();
          else                 spi_rx = ~eng_tx;
          spi_done = 1'b1;
          @(posedge clk);
          #1;
          spi_done = 1'b0;
        end
      end
    end
  end

  task automatic send_cmd(input logic [7:0] b);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    while (!cmd_ready && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check_eq("cmd_accepted", int'(n < 1000), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("reach_idle", int'(busy), 0);
  endtask

  task automatic drain_rsp(input int ncyc);
    rsp_ready = 1'b1;
    repeat (ncyc) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic clear_logs();
    tx_log.delete();
    rsp_log.delete();
    n_start  = 0;
    n_accept = 0;
    cs_low   = 0;
    err_cnt  = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    rsp_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cs_n", int'(cs_n), 1);
    check_eq("rst_start", int'(spi_start), 0);
    check_eq("rst_tx", int'(spi_tx), 'hFF);
    check_eq("rst_ready", int'(cmd_ready), 0);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_rsp_valid", int'(rsp_valid), 0);
    check_eq("rst_rsp_data", int'(rsp_data), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("idle_ready", int'(cmd_ready), 1);

    // Write+read, 2 bytes: cs_n low from accept edge a to a+26
    clear_logs();
    send_cmd(8'hC1);
    send_cmd(8'hA5);
    send_cmd(8'h3C);
    wait_idle();
    check_eq("t1_cs_span", cs_low, 26);
    check_eq("t1_nstart", n_start, 2);
    check_eq("t1_tx0", int'(tx_log[0]), 'hA5);
    check_eq("t1_tx1", int'(tx_log[1]), 'h3C);
    drain_rsp(6);
    check_eq("t1_rsp_n", rsp_log.size(), 2);
    check_eq("t1_rsp0", int'(rsp_log[0]), 'h5A);
    check_eq("t1_rsp1", int'(rsp_log[1]), 'hC3);
    check_eq("t1_err", err_cnt, 0);
    check_eq("t1_cs_end", int'(cs_n), 1);

    // Read-only, 3 bytes
    clear_logs();
    rx_q = '{8'h11, 8'h22, 8'h33};
    send_cmd(8'h42);
    wait_idle();
    check_eq("t2_accepts", n_accept, 1);
    check_eq("t2_nstart", n_start, 3);
    for (int i = 0; i < 3; i++) check_eq("t2_tx_ff", int'(tx_log[i]), 'hFF);
    drain_rsp(6);
    check_eq("t2_rsp_n", rsp_log.size(), 3);
    check_eq("t2_rsp0", int'(rsp_log[0]), 'h11);
    check_eq("t2_rsp1", int'(rsp_log[1]), 'h22);
    check_eq("t2_rsp2", int'(rsp_log[2]), 'h33);

    // 16 reads with back-pressure: stall after byte 5 (4 buffered)
    clear_logs();
    for (int i = 0; i < 16; i++) rx_q.push_back(8'hB0 + 8'(i));
    send_cmd(8'h4F);
    repeat (150) @(posedge clk);
    #1;
    check_eq("t3_stall_nstart", n_start, 5);
    check_eq("t3_stall_cs_n", int'(cs_n), 0);
    check_eq("t3_stall_busy", int'(busy), 1);
    check_eq("t3_stall_head", int'(rsp_data), 'hB0);
    rsp_ready = 1'b1;
    wait_idle();
    drain_rsp(10);
    check_eq("t3_rsp_n", rsp_log.size(), 16);
    for (int i = 0; i < 16; i++) check_eq("t3_rsp", int'(rsp_log[i]), 'hB0 + i);
    check_eq("t3_nstart", n_start, 16);

    // 4 writes, byte 2 never completes -> abort, drain bytes 3 and 4
    clear_logs();
    hang_at = eng_n + 2;
    send_cmd(8'h83);
    send_cmd(8'h11);
    send_cmd(8'h22);
    send_cmd(8'h33);
    send_cmd(8'h44);
    wait_idle();
    check_eq("t4_err_cnt", err_cnt, 1);
    check_eq("t4_err_delay", err_cyc - last_start_cyc, TMO);
    check_eq("t4_cs_at_err", int'(cs_at_err), 1);
    check_eq("t4_accepts", n_accept, 5);
    check_eq("t4_nstart", n_start, 2);
    check_eq("t4_tx1", int'(tx_log[1]), 'h22);
    clear_logs();
    rx_q = '{8'h77};
    send_cmd(8'h40);
    wait_idle();
    drain_rsp(4);
    check_eq("t4b_rsp_n", rsp_log.size(), 1);
    check_eq("t4b_rsp0", int'(rsp_log[0]), 'h77);
    check_eq("t4b_tx0", int'(tx_log[0]), 'hFF);
    check_eq("t4b_err", err_cnt, 0);

    // 20-cycle gap between payload bytes
    clear_logs();
    send_cmd(8'h81);
    send_cmd(8'h5E);
    base = n_start;
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (cs_n || !busy) viol++;
    end
    check_eq("t5_gap_starts", n_start - base, 1);
    check_eq("t5_gap_viol", viol, 0);
    @(posedge clk);
    #1;
    send_cmd(8'hE7);
    wait_idle();
    check_eq("t5_nstart", n_start, 2);
    check_eq("t5_tx0", int'(tx_log[0]), 'h5E);
    check_eq("t5_tx1", int'(tx_log[1]), 'hE7);

    // Reset during byte 2 with one byte buffered
    clear_logs();
    send_cmd(8'hC1);
    send_cmd(8'h0F);
    send_cmd(8'hF0);
    check_eq("t6_pre_rsp_valid", int'(rsp_valid), 1);
    check_eq("t6_pre_cs_n", int'(cs_n), 0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_rst_cs_n", int'(cs_n), 1);
    check_eq("t6_rst_busy", int'(busy), 0);
    check_eq("t6_rst_rsp_valid", int'(rsp_valid), 0);
    check_eq("t6_rst_start", int'(spi_start), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    clear_logs();
    send_cmd(8'hC0);
    send_cmd(8'h96);
    wait_idle();
    drain_rsp(4);
    check_eq("t6_tx0", int'(tx_log[0]), 'h96);
    check_eq("t6_rsp_n", rsp_log.size(), 1);
    check_eq("t6_rsp0", int'(rsp_log[0]), 'h69);
    check_eq("t6_cs_span", cs_low, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_xfer_sequencer.md
Name: spi_xfer_sequencer

Overview:
Sequences framed SPI transactions for the I2C-to-SPI bridge. Parses a command byte stream produced by the I2C slave side and drives chip select. Issues one byte-transfer request at a time to the SPI byte engine (sck/mosi/miso shifter). Buffers captured MISO bytes in a small FIFO for the I2C side to read back.

Parameters:
RSP_DEPTH, 4, response FIFO depth in bytes (power of two, >=2)
CS_SETUP, 2, cycles cs_n is held low before the first byte starts
CS_HOLD, 2, cycles after the last byte's done before cs_n goes high
TIMEOUT, 255, max cycles from spi_start to spi_done before abort (>=1)

Ports:
i2c_wb_clk_i  in  1  system clock, all logic rising-edge
i2c_wb_rst_i  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command byte available
cmd_data  in  8  command byte (header, then write payload)
cmd_ready  out  1  command byte accepted this cycle when valid&ready
spi_start  out  1  one-cycle pulse: engine begins a byte transfer
spi_tx  out  8  byte to shift out; stable from start until done
spi_done  in  1  one-cycle pulse: engine finished the byte
spi_rx  in  8  byte shifted in; valid in the spi_done cycle
cs_n  out  1  SPI chip select, active-low
rsp_valid  out  1  response FIFO not empty
rsp_data  out  8  FIFO head (first-word-fall-through)
rsp_ready  in  1  pop head when rsp_valid&rsp_ready
busy  out  1  high in every state except IDLE
err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async assert, sync release): state IDLE, cs_n=1, spi_start=0, spi_tx=8'hFF, cmd_ready=0, err=0, busy=0, FIFO empty (rsp_valid=0, rsp_data=8'h00), all counters 0.
- Header byte: bit7 W (payload bytes follow), bit6 R (capture rx), bits5:4 ignored, bits3:0 LEN-1 (1..16 bytes).
- IDLE: cmd_ready=1. On accept, latch W, R and remaining=LEN, then go to SETUP. cs_n goes low in the cycle after accept.
- SETUP: count CS_SETUP cycles, then go to LOAD.
- LOAD, W=1: cmd_ready=1. On accept, spi_tx<=cmd_data and go to XFER. Waits indefinitely for cmd_valid.
- LOAD, W=0: spi_tx<=8'hFF, no accept, go to XFER next cycle.
- XFER: spi_start pulses in the first XFER cycle only, and the timeout counter starts.
  - On spi_done with R=1, go to STORE. On spi_done with R=0, go to NEXT.
  - If the counter reaches TIMEOUT with no done: pulse err, go to DRAIN.
- STORE: push spi_rx into the FIFO when not full, then go to NEXT. If the FIFO is full, stall here with spi_rx held in a capture register. No byte is ever dropped.
- NEXT: remaining-=1. If it becomes 0, go to HOLD; else go to LOAD.
  - spi_start for consecutive bytes is separated by >=2 cycles.
- HOLD: count CS_HOLD cycles. cs_n=1 on exit to IDLE.
- DRAIN (abort): cs_n=1 immediately.
  - If W=1, accept and discard the remaining payload bytes so the next header stays aligned.
  - Then go to IDLE. A late spi_done is ignored.
- FIFO: push and pop in the same cycle are both legal when full or empty+push is not involved. Pop when empty is ignored. Count width is log2(RSP_DEPTH)+1. Pointers wrap modulo RSP_DEPTH.
- cmd_ready is never high outside IDLE, LOAD(W=1) and DRAIN(W=1).
- Reset mid-transaction: immediate return to reset values, including cs_n=1 and FIFO flushed.

Test Plan:
- Header 8'hC1 then payload 8'hA5, 8'h3C; engine echoes rx=~tx with done 8 cycles after start -> cs_n low for exactly the span of 2 transfers plus CS_SETUP/CS_HOLD; spi_tx sequence A5, 3C; FIFO yields 5A, C3.
- Header 8'h42 (read-only, 3 bytes), rx bytes 11, 22, 33 -> spi_tx=FF for all three, no payload accepted, rsp_data 11, 22, 33.
- Header 8'h4F (16 reads), rsp_ready=0 -> sequencer stalls in STORE after byte 5 with 4 bytes buffered, cs_n still low. Release rsp_ready -> all 16 bytes delivered in order, none lost.
- Header 8'h83 (4 writes), engine never returns done on byte 2 -> err pulses TIMEOUT cycles after that start, cs_n rises, remaining 2 payload bytes consumed. A following header 8'h40 executes normally.
- cmd_valid gap of 20 cycles between payload bytes -> cs_n stays low, no spurious spi_start, busy=1 throughout.
- Assert i2c_wb_rst_i during XFER of byte 2 with FIFO holding 1 byte -> same cycle: cs_n=1, busy=0, rsp_valid=0; after release, a new 8'hC0 transaction completes correctly.
